// File: rtl/axi4lite_arbiter_if.sv
// AXI4-Lite bus bundle shared by the arbiter's requester ports and its downstream port.
// The master modport drives requests, the slave modport answers them.
interface axi4lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  aclk;
    logic                  aresetn;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        output aclk, aresetn,
        output arvalid, araddr, arprot, input arready,
        input  rvalid, rdata, rresp, output rready,
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input  bvalid, bresp, output bready
    );

    modport slave (
        input  arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready,
        input  awvalid, awaddr, awprot, output awready,
        input  wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready
    );
endinterface

// File: rtl/axi4lite_arbiter.sv
// Two-master to one-slave AXI4-Lite arbiter (m0 = instruction fetch, m1 = load/store).
// Read and write channels each carry one outstanding transaction and are arbitrated
// independently. Request beats are buffered on the master-side handshake.
// Build option: define AXI_ARB_FIXED_PRIORITY_EN to make m1 win every tie on both
// channels; otherwise ties are settled round-robin starting from RR_INIT.
module axi4lite_arbiter #(
    parameter int unsigned RR_INIT = 0,
    parameter int          ADDR_W  = 32,
    parameter int          DATA_W  = 64
) (
    input  logic    clk,
    input  logic    rst,
    axi4lite.slave  m0,
    axi4lite.slave  m1,
    axi4lite.master out
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_ISSUE, W_RESP} w_state_e;

    // Returns the winning master index: a sole requester wins, a tie goes to 'tie'.
    function automatic logic pick(input logic req0, input logic req1, input logic tie);
        return (req0 && req1) ? tie : req1;
    endfunction

    assign out.aclk    = clk;
    assign out.aresetn = !rst;

    r_state_e              r_state_q, r_state_d;
    logic                  r_gnt_q, r_gnt_d;
    logic                  r_done;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic [2:0]            arprot_q, arprot_d;

    w_state_e              w_state_q, w_state_d;
    logic                  w_gnt_q, w_gnt_d;
    logic                  w_done;
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [2:0]            awprot_q, awprot_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;

    logic                  w_take, w_src, aw_open, w_open;
    logic                  src_awvalid, src_wvalid;
    logic                  r_tie, w_tie;

`ifdef AXI_ARB_FIXED_PRIORITY_EN
    assign r_tie = 1'b1;
    assign w_tie = 1'b1;
`else
    localparam logic PRIO_RST = (RR_INIT != 0);

    logic r_prio_q, r_prio_d;
    logic w_prio_q, w_prio_d;

    assign r_tie = r_prio_q;
    assign w_tie = w_prio_q;

    // Priority pointers hand the next tie to the master that was not just served.
    always_comb begin
        r_prio_d = r_done ? !r_gnt_q : r_prio_q;
        w_prio_d = w_done ? !w_gnt_q : w_prio_q;
    end

    // Priority pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_q <= PRIO_RST;
            w_prio_q <= PRIO_RST;
        end else begin
            r_prio_q <= r_prio_d;
            w_prio_q <= w_prio_d;
        end
    end
`endif

    // Read channel: arbitrate AR, replay it downstream, route R back to the grantee.
    always_comb begin
        r_state_d  = r_state_q;
        r_gnt_d    = r_gnt_q;
        araddr_d   = araddr_q;
        arprot_d   = arprot_q;
        r_done     = 1'b0;

        m0.arready = 1'b0;
        m1.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m1.rvalid  = 1'b0;
        m0.rdata   = out.rdata;
        m1.rdata   = out.rdata;
        m0.rresp   = out.rresp;
        m1.rresp   = out.rresp;

        out.arvalid = 1'b0;
        out.araddr  = araddr_q;
        out.arprot  = arprot_q;
        out.rready  = 1'b0;

        case (r_state_q)
            R_IDLE: begin
                // Readies are held low while reset is asserted so nothing is accepted then.
                if (!rst && (m0.arvalid || m1.arvalid)) begin
                    r_gnt_d = pick(m0.arvalid, m1.arvalid, r_tie);
                    if (r_gnt_d) begin
                        m1.arready = 1'b1;
                        araddr_d   = m1.araddr;
                        arprot_d   = m1.arprot;
                    end else begin
                        m0.arready = 1'b1;
                        araddr_d   = m0.araddr;
                        arprot_d   = m0.arprot;
                    end
                    r_state_d = R_ISSUE;
                end
            end
            R_ISSUE: begin
                out.arvalid = 1'b1;
                if (out.arready) begin
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_gnt_q) begin
                    m1.rvalid  = out.rvalid;
                    out.rready = m1.rready;
                end else begin
                    m0.rvalid  = out.rvalid;
                    out.rready = m0.rready;
                end
                if (out.rvalid && out.rready) begin
                    r_done    = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read channel control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_gnt_q   <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_gnt_q   <= r_gnt_d;
        end
    end

    // Read address buffer; contents only matter while out.arvalid is high.
    always_ff @(posedge clk) begin
        araddr_q <= araddr_d;
        arprot_q <= arprot_d;
    end

    // Write channel: collect AW and W from the grantee, issue both, route B back.
    // aw_full/w_full mean "captured, not yet accepted downstream".
    always_comb begin
        w_state_d   = w_state_q;
        w_gnt_d     = w_gnt_q;
        aw_full_d   = aw_full_q;
        w_full_d    = w_full_q;
        awaddr_d    = awaddr_q;
        awprot_d    = awprot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        w_done      = 1'b0;
        w_take      = 1'b0;
        w_src       = w_gnt_q;
        aw_open     = 1'b0;
        w_open      = 1'b0;
        src_awvalid = 1'b0;
        src_wvalid  = 1'b0;

        m0.awready = 1'b0;
        m1.awready = 1'b0;
        m0.wready  = 1'b0;
        m1.wready  = 1'b0;
        m0.bvalid  = 1'b0;
        m1.bvalid  = 1'b0;
        m0.bresp   = out.bresp;
        m1.bresp   = out.bresp;

        out.awvalid = 1'b0;
        out.awaddr  = awaddr_q;
        out.awprot  = awprot_q;
        out.wvalid  = 1'b0;
        out.wdata   = wdata_q;
        out.wstrb   = wstrb_q;
        out.bready  = 1'b0;

        case (w_state_q)
            W_IDLE: begin
                w_src   = pick(m0.awvalid || m0.wvalid, m1.awvalid || m1.wvalid, w_tie);
                w_take  = !rst && (m0.awvalid || m0.wvalid || m1.awvalid || m1.wvalid);
                aw_open = 1'b1;
                w_open  = 1'b1;
            end
            W_COLLECT: begin
                w_take  = !rst;
                aw_open = !aw_full_q;
                w_open  = !w_full_q;
            end
            W_ISSUE: begin
                out.awvalid = aw_full_q;
                out.wvalid  = w_full_q;
                if (out.awready) begin
                    aw_full_d = 1'b0;
                end
                if (out.wready) begin
                    w_full_d = 1'b0;
                end
                if (!aw_full_d && !w_full_d) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (w_gnt_q) begin
                    m1.bvalid  = out.bvalid;
                    out.bready = m1.bready;
                end else begin
                    m0.bvalid  = out.bvalid;
                    out.bready = m0.bready;
                end
                if (out.bvalid && out.bready) begin
                    w_done    = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        // Shared capture path for W_IDLE (new grant) and W_COLLECT (locked grant).
        if (w_take) begin
            src_awvalid = w_src ? m1.awvalid : m0.awvalid;
            src_wvalid  = w_src ? m1.wvalid  : m0.wvalid;
            if (w_src) begin
                m1.awready = aw_open;
                m1.wready  = w_open;
            end else begin
                m0.awready = aw_open;
                m0.wready  = w_open;
            end
            if (aw_open && src_awvalid) begin
                aw_full_d = 1'b1;
                awaddr_d  = w_src ? m1.awaddr : m0.awaddr;
                awprot_d  = w_src ? m1.awprot : m0.awprot;
            end
            if (w_open && src_wvalid) begin
                w_full_d = 1'b1;
                wdata_d  = w_src ? m1.wdata : m0.wdata;
                wstrb_d  = w_src ? m1.wstrb : m0.wstrb;
            end
            w_gnt_d   = w_src;
            w_state_d = (aw_full_d && w_full_d) ? W_ISSUE : W_COLLECT;
        end
    end

    // Write channel control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_gnt_q   <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_gnt_q   <= w_gnt_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
        end
    end

    // Write address/data buffers; contents only matter while the matching valid is high.
    always_ff @(posedge clk) begin
        awaddr_q <= awaddr_d;
        awprot_q <= awprot_d;
        wdata_q  <= wdata_d;
        wstrb_q  <= wstrb_d;
    end
endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Directed bench for axi4lite_arbiter: the bench plays both requesters and the
// downstream slave, stepping one cycle at a time and sampling 1 unit after each edge.
module tb_axi4lite_arbiter;
    logic clk;
    logic rst;

    int n_cmp;
    int n_mis;

    axi4lite #(.ADDR_W(32), .DATA_W(64)) m0_if ();
    axi4lite #(.ADDR_W(32), .DATA_W(64)) m1_if ();
    axi4lite #(.ADDR_W(32), .DATA_W(64)) out_if ();

    assign m0_if.aclk    = clk;
    assign m0_if.aresetn = !rst;
    assign m1_if.aclk    = clk;
    assign m1_if.aresetn = !rst;

    axi4lite_arbiter #(.RR_INIT(0), .ADDR_W(32), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .m0  (m0_if),
        .m1  (m1_if),
        .out (out_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        m0_if.arvalid = 0; m0_if.araddr = 0; m0_if.arprot = 0; m0_if.rready = 0;
        m0_if.awvalid = 0; m0_if.awaddr = 0; m0_if.awprot = 0;
        m0_if.wvalid = 0; m0_if.wdata = 0; m0_if.wstrb = 0; m0_if.bready = 0;
        m1_if.arvalid = 0; m1_if.araddr = 0; m1_if.arprot = 0; m1_if.rready = 0;
        m1_if.awvalid = 0; m1_if.awaddr = 0; m1_if.awprot = 0;
        m1_if.wvalid = 0; m1_if.wdata = 0; m1_if.wstrb = 0; m1_if.bready = 0;
        out_if.arready = 0; out_if.rvalid = 0; out_if.rdata = 0; out_if.rresp = 0;
        out_if.awready = 0; out_if.wready = 0; out_if.bvalid = 0; out_if.bresp = 0;
    endtask

    // Both masters request together; the slave answers every read at once.
    // Records which master handshakes AR first and second.
    task automatic read_pair(input string tag, input bit exp_first);
        int first;
        int second;
        bit g0;
        bit g1;
        first  = -1;
        second = -1;
        m0_if.araddr = 32'h0;  m0_if.arvalid = 1; m0_if.rready = 1;
        m1_if.araddr = 32'h8;  m1_if.arvalid = 1; m1_if.rready = 1;
        out_if.arready = 1; out_if.rvalid = 1; out_if.rdata = 64'h5;
        for (int c = 0; c < 20 && second < 0; c++) begin
            #1;
            g0 = m0_if.arvalid && m0_if.arready;
            g1 = m1_if.arvalid && m1_if.arready;
            if (g0 || g1) begin
                if (first < 0) first = g1 ? 1 : 0;
                else           second = g1 ? 1 : 0;
            end
            tick();
            if (g0) m0_if.arvalid = 0;
            if (g1) m1_if.arvalid = 0;
        end
        repeat (3) tick();
        out_if.rvalid = 0;
        m0_if.arvalid = 0;
        m1_if.arvalid = 0;
        check({tag, "_first"}, 64'(first), 64'(exp_first));
        check({tag, "_second"}, 64'(second), 64'(!exp_first));
    endtask

    initial begin
        int hold_hits;
        n_cmp = 0;
        n_mis = 0;
        init_inputs();
        rst = 1;
        repeat (3) tick();

        // Reset state
        check("rst_out_arvalid", out_if.arvalid, 0);
        check("rst_out_awvalid", out_if.awvalid, 0);
        check("rst_out_wvalid",  out_if.wvalid, 0);
        check("rst_out_rready",  out_if.rready, 0);
        check("rst_out_bready",  out_if.bready, 0);
        check("rst_m0_rvalid",   m0_if.rvalid, 0);
        check("rst_m1_bvalid",   m1_if.bvalid, 0);
        check("rst_aresetn",     out_if.aresetn, 0);
        rst = 0;
        tick();
        check("run_aresetn", out_if.aresetn, 1);

        // Single read from m1, valid for one cycle only
        m1_if.arvalid = 1; m1_if.araddr = 32'h1000; m1_if.rready = 1; out_if.arready = 1;
        #1;
        check("rd1_m1_arready", m1_if.arready, 1);
        check("rd1_m0_arready", m0_if.arready, 0);
        check("rd1_out_arvalid_n", out_if.arvalid, 0);
        tick();
        m1_if.arvalid = 0;
        #1;
        check("rd1_out_arvalid", out_if.arvalid, 1);
        check("rd1_out_araddr", 64'(out_if.araddr), 64'h1000);
        tick();
        out_if.rvalid = 1; out_if.rdata = 64'hDEADBEEF_CAFEF00D; out_if.rresp = 2'b00;
        #1;
        check("rd1_m1_rvalid", m1_if.rvalid, 1);
        check("rd1_m1_rdata", m1_if.rdata, 64'hDEADBEEF_CAFEF00D);
        check("rd1_m1_rresp", 64'(m1_if.rresp), 0);
        check("rd1_m0_rvalid", m0_if.rvalid, 0);
        check("rd1_out_rready", out_if.rready, 1);
        tick();
        out_if.rvalid = 0;
        #1;
        check("rd1_m1_rvalid_done", m1_if.rvalid, 0);

        // Simultaneous reads
`ifdef AXI_ARB_FIXED_PRIORITY_EN
        read_pair("pairA", 1'b1);
`else
        read_pair("pairA", 1'b0);
`endif
        // m0 alone: after it is served the pointer favours m1
        m0_if.arvalid = 1; m0_if.araddr = 32'h20; m0_if.rready = 1;
        out_if.arready = 1; out_if.rvalid = 1;
        tick();
        m0_if.arvalid = 0;
        repeat (3) tick();
        out_if.rvalid = 0;
        read_pair("pairB", 1'b1);

        // Write with split handshake: slave takes W at once, holds off AW for 3 cycles
        m1_if.awvalid = 1; m1_if.awaddr = 32'h2000;
        m1_if.wvalid = 1; m1_if.wdata = 64'h11223344_55667788; m1_if.wstrb = 8'h0F;
        m1_if.bready = 1; out_if.awready = 0; out_if.wready = 1;
        #1;
        check("wr_m1_awready", m1_if.awready, 1);
        check("wr_m1_wready", m1_if.wready, 1);
        check("wr_m0_awready", m0_if.awready, 0);
        tick();
        m1_if.awvalid = 0; m1_if.wvalid = 0;
        #1;
        check("wr_iss_wvalid", out_if.wvalid, 1);
        check("wr_iss_awvalid", out_if.awvalid, 1);
        check("wr_iss_wdata", out_if.wdata, 64'h11223344_55667788);
        check("wr_iss_wstrb", 64'(out_if.wstrb), 64'h0F);
        tick();
        #1;
        check("wr_wvalid_dropped", out_if.wvalid, 0);
        check("wr_awvalid_held", out_if.awvalid, 1);
        check("wr_awaddr", 64'(out_if.awaddr), 64'h2000);
        tick();
        out_if.awready = 1;
        #1;
        check("wr_awvalid_held3", out_if.awvalid, 1);
        check("wr_bvalid_early", m1_if.bvalid, 0);
        tick();
        out_if.awready = 0; out_if.bvalid = 1; out_if.bresp = 2'b00;
        #1;
        check("wr_m1_bvalid", m1_if.bvalid, 1);
        check("wr_m0_bvalid", m0_if.bvalid, 0);
        check("wr_out_bready", out_if.bready, 1);
        tick();
        out_if.bvalid = 0;
        #1;
        check("wr_m1_bvalid_done", m1_if.bvalid, 0);

        // Concurrent read (m0) and write (m1)
        m0_if.arvalid = 1; m0_if.araddr = 32'h40; m0_if.rready = 1;
        m1_if.awvalid = 1; m1_if.awaddr = 32'h80; m1_if.wvalid = 1;
        m1_if.wdata = 64'hA5; m1_if.wstrb = 8'hFF; m1_if.bready = 1;
        out_if.arready = 1; out_if.awready = 1; out_if.wready = 1;
        #1;
        check("cc_m0_arready", m0_if.arready, 1);
        check("cc_m1_awready", m1_if.awready, 1);
        tick();
        m0_if.arvalid = 0; m1_if.awvalid = 0; m1_if.wvalid = 0;
        #1;
        check("cc_out_araddr", 64'(out_if.araddr), 64'h40);
        check("cc_out_awaddr", 64'(out_if.awaddr), 64'h80);
        check("cc_both_valid", {out_if.arvalid, out_if.awvalid, out_if.wvalid}, 3'b111);
        tick();
        out_if.rvalid = 1; out_if.rdata = 64'h1234; out_if.bvalid = 1;
        #1;
        check("cc_m0_rvalid", m0_if.rvalid, 1);
        check("cc_m1_rvalid", m1_if.rvalid, 0);
        check("cc_m1_bvalid", m1_if.bvalid, 1);
        check("cc_m0_bvalid", m0_if.bvalid, 0);
        tick();
        out_if.rvalid = 0; out_if.bvalid = 0;

        // Back-to-back reads from m1 against a slow slave
        m1_if.arvalid = 1; m1_if.araddr = 32'h100; m1_if.rready = 1; out_if.arready = 1;
        tick();
        m1_if.araddr = 32'h108;
        #1;
        check("b2b_issue_arready", m1_if.arready, 0);
        tick();
        hold_hits = 0;
        for (int c = 0; c < 10; c++) begin
            if (m1_if.arready) hold_hits++;
            tick();
        end
        check("b2b_hold_arready", 64'(hold_hits), 0);
        out_if.rvalid = 1; out_if.rdata = 64'h77;
        #1;
        check("b2b_r_to_m1", m1_if.rvalid, 1);
        check("b2b_arready_at_r", m1_if.arready, 0);
        tick();
        out_if.rvalid = 0;
        #1;
        check("b2b_arready_after", m1_if.arready, 1);
        tick();
        m1_if.arvalid = 0;
        #1;
        check("b2b_second_arvalid", out_if.arvalid, 1);
        check("b2b_second_araddr", 64'(out_if.araddr), 64'h108);
        tick();
        out_if.rvalid = 1;
        tick();
        out_if.rvalid = 0;

        // Reset while a write sits in W_ISSUE
        out_if.awready = 0; out_if.wready = 0;
        m0_if.awvalid = 1; m0_if.awaddr = 32'h300; m0_if.wvalid = 1; m0_if.wdata = 64'h9;
        tick();
        m0_if.awvalid = 0; m0_if.wvalid = 0;
        #1;
        check("rstw_issuing", out_if.awvalid, 1);
        rst = 1;
        m0_if.arvalid = 1; m0_if.araddr = 32'h500;
        tick();
        check("rstw_awvalid", out_if.awvalid, 0);
        check("rstw_wvalid", out_if.wvalid, 0);
        check("rstw_arvalid", out_if.arvalid, 0);
        check("rstw_m0_arready", m0_if.arready, 0);
        check("rstw_m0_awready", m0_if.awready, 0);
        check("rstw_m0_bvalid", m0_if.bvalid, 0);
        rst = 0;
        out_if.arready = 1; m0_if.rready = 1;
        #1;
        check("rstw_fresh_arready", m0_if.arready, 1);
        tick();
        m0_if.arvalid = 0;
        #1;
        check("rstw_fresh_araddr", 64'(out_if.araddr), 64'h500);
        check("rstw_write_idle", out_if.awvalid, 0);
        tick();
        out_if.rvalid = 1; out_if.rdata = 64'hBEEF;
        #1;
        check("rstw_fresh_rvalid", m0_if.rvalid, 1);
        check("rstw_fresh_rdata", m0_if.rdata, 64'hBEEF);
        tick();
        out_if.rvalid = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/axi4lite_arbiter.md
Name: axi4lite_arbiter

Overview:
- Two-master to one-slave AXI4-Lite arbiter. It shares the single external data bus between instruction fetch (m0) and the load/store unit (m1).
- Read and write channels are arbitrated independently. Each channel has one outstanding transaction.
- AR, AW and W are captured in internal buffers on the master-side handshake. A master whose valid is asserted for only one cycle therefore completes its request when it is granted that same cycle, which the load/store unit relies on for AR.

Parameters:
- RR_INIT, 0, which master (0 or 1) holds round-robin priority after reset, on each channel.

Ports:
- clk  input  1  clock; also driven onto out.aclk.
- rst  input  1  synchronous active-high reset; out.aresetn = !rst.
- m0  axi4lite.slave  interface  requester 0 (instruction fetch).
- m1  axi4lite.slave  interface  requester 1 (load/store unit).
- out  axi4lite.master  interface  shared downstream bus.

Interface: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Reset:
  - Both channel FSMs go to IDLE; priority pointers = RR_INIT.
  - All out.*valid = 0; out.rready = 0; out.bready = 0.
  - All m*.arready/awready/wready = 0; all m*.rvalid/bvalid = 0.
  - Reset mid-transaction abandons it with no completion to the master; the downstream slave is reset through aresetn.
- Read FSM, states R_IDLE, R_ISSUE, R_DATA:
  - R_IDLE:
    - Winner = the only requester with arvalid, or the priority master if both request.
    - Winner's arready = 1 combinationally; loser's arready = 0.
    - On the handshake, latch araddr, arprot and grant id; go to R_ISSUE.
  - R_ISSUE: out.arvalid = 1 from the buffer. On out.arready, go to R_DATA.
  - R_DATA:
    - Route out.rvalid/rdata/rresp to the granted master only; out.rready = granted master's rready.
    - On rvalid && rready: go to R_IDLE; priority pointer = the non-granted master.
  - Minimum latency: AR accepted in cycle N, out.arvalid asserted in cycle N+1.
- Write FSM, states W_IDLE, W_COLLECT, W_ISSUE, W_RESP:
  - W_IDLE:
    - Winner chosen among masters with awvalid || wvalid, same priority rule as read.
    - Winner's awready = 1 and wready = 1; capture whichever of AW and W handshakes; lock the grant.
    - If both are captured, go to W_ISSUE, otherwise W_COLLECT.
  - W_COLLECT: granted master's awready/wready = 1 only while the corresponding buffer is empty. When both buffers are full, go to W_ISSUE.
  - W_ISSUE:
    - out.awvalid and out.wvalid are driven from the buffers and each drops independently after its handshake. The same-cycle case is allowed.
    - When both have handshaked, go to W_RESP.
  - W_RESP:
    - Route bvalid/bresp to the granted master; out.bready = granted master's bready.
    - On the handshake: go to W_IDLE; priority pointer flips to the other master.
- Non-granted masters always see ready = 0 and valid = 0 on that channel.
- Read and write channels run concurrently; no ordering between them is enforced. Masters must not overlap a read and a write to the same address.
- A master deasserting valid before its handshake in R_IDLE/W_IDLE is legal: no grant is taken.
- All registered outputs must be free of X after reset. When the corresponding valid is 0, data buses are don't-care.

Optional Feature:
- Macro AXI_ARB_FIXED_PRIORITY_EN.
- Defined: m1 (load/store) always wins simultaneous requests on both channels; priority pointers and RR_INIT are unused.
- Undefined: round-robin as specified above.

Test Plan:
- Single read: m1 arvalid for one cycle with araddr=0x1000, out.arready=1 → m1.arready=1 the same cycle; out.arvalid=1 with araddr=0x1000 next cycle; out.rdata=0xDEADBEEF_CAFEF00D with rresp=OKAY returned to m1 only; m0.rvalid stays 0.
- Simultaneous reads: m0 araddr=0x0 and m1 araddr=0x8 in the same cycle, RR_INIT=0 → m0 is granted first and m1 second. A repeat pair then grants m1 first. With AXI_ARB_FIXED_PRIORITY_EN, m1 is granted first both times.
- Write split handshake: m1 awvalid/wvalid with awaddr=0x2000, wdata=0x11223344_55667788, wstrb=0x0F; out.awready is held 0 for 3 cycles while out.wready=1 → out.wvalid drops after one cycle, out.awvalid is held, and bvalid is routed to m1 after both handshakes.
- Concurrent channels: m0 read of 0x40 while m1 writes 0x80 → both proceed in overlapping cycles with correct routing and no cross-delivery of rvalid/bvalid.
- Back-to-back slow slave: out.rvalid delayed 10 cycles while m1 holds a second arvalid → m1.arready stays 0 until the first R handshake completes, and the second read is issued the cycle after.
- Reset mid-write in W_ISSUE → the next cycle shows all valids and readies at 0, both FSMs in IDLE, and a fresh m0 read completes normally.
